sprite_compositor: RTL and testbench

- Parametrised successor to the fixed-object pixel drawer used by the game top level.
- Takes NUM_SPR rectangular sprites, each with its own enable and 12-bit RGB colour, and composites them by priority onto a background colour.
- Output is a registered 4/4/4 VGA colour, advanced on the pixel strobe.
- Adds two features the old drawer lacks: per-frame overlap (collision) reporting, and a game-over flash/blank sequence driven by a frame-level state machine.
- Sits between the vga640x480 driver and the VGA pins.

---
 rtl/sprite_compositor_if.sv | 37 +++
 rtl/sprite_compositor.sv | 157 +++++++++++++++
 tb/tb_sprite_compositor.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sprite_compositor_if.sv
// Pixel, sprite-table and colour bundle between the VGA driver side and the compositor.
// The master drives the scan position and sprite table; the slave returns colour, overlap and state.
interface sprite_compositor_if #(
    parameter int unsigned NUM_SPR = 6
);
    logic                    i_pix_stb;
    logic [9:0]              i_x;
    logic [8:0]              i_y;
    logic                    i_frame;
    logic [12*NUM_SPR-1:0]   i_spr_x1;
    logic [12*NUM_SPR-1:0]   i_spr_x2;
    logic [12*NUM_SPR-1:0]   i_spr_y1;
    logic [12*NUM_SPR-1:0]   i_spr_y2;
    logic [NUM_SPR-1:0]      i_spr_en;
    logic [12*NUM_SPR-1:0]   i_spr_rgb;
    logic [11:0]             i_bg_rgb;
    logic                    i_gameover;
    logic [3:0]              o_r;
    logic [3:0]              o_g;
    logic [3:0]              o_b;
    logic [NUM_SPR-1:0]      o_overlap;
    logic [1:0]              o_state;

    modport master (
        output i_pix_stb, i_x, i_y, i_frame,
        output i_spr_x1, i_spr_x2, i_spr_y1, i_spr_y2, i_spr_en, i_spr_rgb,
        output i_bg_rgb, i_gameover,
        input  o_r, o_g, o_b, o_overlap, o_state
    );

    modport slave (
        input  i_pix_stb, i_x, i_y, i_frame,
        input  i_spr_x1, i_spr_x2, i_spr_y1, i_spr_y2, i_spr_en, i_spr_rgb,
        input  i_bg_rgb, i_gameover,
        output o_r, o_g, o_b, o_overlap, o_state
    );
endinterface

// File: rtl/sprite_compositor.sv
// Priority compositor for NUM_SPR rectangular sprites over a background, with a two-strobe
// colour pipeline, per-frame collision mask and a frame-level game-over flash sequence.
module sprite_compositor #(
    parameter int unsigned NUM_SPR      = 6,
    parameter int unsigned FLASH_FRAMES = 120,
    parameter int unsigned FLASH_PERIOD = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sprite_compositor_if.slave bus
);

    localparam int unsigned CW = $clog2(FLASH_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_FLASH = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    logic [11:0]        px;
    logic [11:0]        py;
    logic [NUM_SPR-1:0] hit_c;
    logic [11:0]        win_rgb_c;

    logic [11:0]        s1_rgb;
    logic [11:0]        s1_bg;
    logic               s1_any;
    logic [NUM_SPR-1:0] s1_hit;
    logic [11:0]        rgb_q;

    logic [NUM_SPR-1:0] sticky_q;
    logic [NUM_SPR-1:0] sticky_nxt;
    logic [NUM_SPR-1:0] overlap_q;
    logic               multi_hit;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic               vis_q, vis_d;
    logic               flash_wrap;
    logic               visible;

    assign px = {2'b00, bus.i_x};
    assign py = {3'b000, bus.i_y};

    // Walk from the highest index down so the lowest-index hitting sprite is written last and wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        hit_c     = '0;
        win_rgb_c = bus.i_bg_rgb;
        for (int k = NUM_SPR - 1; k >= 0; k--) begin
            if (bus.i_spr_en[k] &&
                px > bus.i_spr_x1[12*k +: 12] && px < bus.i_spr_x2[12*k +: 12] &&
                py > bus.i_spr_y1[12*k +: 12] && py < bus.i_spr_y2[12*k +: 12]) begin
                hit_c[k]  = 1'b1;
                win_rgb_c = bus.i_spr_rgb[12*k +: 12];
            end
        end
    end

    assign visible = (state_q == ST_PLAY) || ((state_q == ST_FLASH) && vis_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_rgb <= '0;
            s1_bg  <= '0;
            s1_any <= 1'b0;
            s1_hit <= '0;
            rgb_q  <= '0;
        end else if (bus.i_pix_stb) begin
            // NOTE: non-blocking assignments let stage 2 consume the stage-1 value from before this edge.
            s1_rgb <= win_rgb_c;
            s1_bg  <= bus.i_bg_rgb;
            s1_any <= |hit_c;
            s1_hit <= hit_c;
            rgb_q  <= (s1_any && visible) ? s1_rgb : s1_bg;
        end
    end

    // Clearing the lowest set bit leaves something only when two or more sprites hit.
    assign multi_hit  = |(s1_hit & (s1_hit - NUM_SPR'(1)));
    assign sticky_nxt = sticky_q | ((bus.i_pix_stb && multi_hit) ? s1_hit : '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sticky_q  <= '0;
            overlap_q <= '0;
        end else if (bus.i_frame) begin
            overlap_q <= sticky_nxt;
            sticky_q  <= '0;
        end else begin
            sticky_q  <= sticky_nxt;
        end
    end

    assign cnt_inc    = cnt_q + CW'(1);
    assign flash_wrap = ((32'(cnt_inc) % FLASH_PERIOD) == 0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vis_d   = vis_q;
        if (bus.i_frame) begin
            case (state_q)
                ST_PLAY: begin
                    if (bus.i_gameover) begin
                        state_d = ST_FLASH;
                        cnt_d   = '0;
                        vis_d   = 1'b0;
                    end
                end
                ST_FLASH: begin
                    if (!bus.i_gameover) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                        vis_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (flash_wrap) vis_d = ~vis_q;
                        if (32'(cnt_inc) == FLASH_FRAMES) state_d = ST_OVER;
                    end
                end
                ST_OVER: begin
                    if (!bus.i_gameover) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                        vis_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_PLAY;
                    cnt_d   = '0;
                    vis_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_PLAY;
            cnt_q   <= '0;
            vis_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vis_q   <= vis_d;
        end
    end

    assign bus.o_r       = rgb_q[11:8];
    assign bus.o_g       = rgb_q[7:4];
    assign bus.o_b       = rgb_q[3:0];
    assign bus.o_overlap = overlap_q;
    assign bus.o_state   = state_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: hit edges, priority, overlap publishing,
// flash/over sequence, asynchronous reset and strobe gating.
module tb_sprite_compositor;

    localparam int unsigned NSPR = 6;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    sprite_compositor_if #(.NUM_SPR(NSPR)) bus ();

    sprite_compositor #(
        .NUM_SPR     (NSPR),
        .FLASH_FRAMES(4),
        .FLASH_PERIOD(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {20'd0, bus.o_r, bus.o_g, bus.o_b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [9:0] x, input logic [8:0] y);
        bus.i_x       = x;
        bus.i_y       = y;
        bus.i_pix_stb = 1'b1;
        step();
        bus.i_pix_stb = 1'b0;
    endtask

    task automatic frame();
        bus.i_frame = 1'b1;
        step();
        bus.i_frame = 1'b0;
    endtask

    // Two strobes on the same pixel so the output reflects it.
    task automatic show(input logic [9:0] x, input logic [8:0] y);
        strobe(x, y);
        strobe(x, y);
    endtask

    task automatic set_spr(input int k, input logic [11:0] x1, input logic [11:0] x2,
                           input logic [11:0] y1, input logic [11:0] y2,
                           input logic [11:0] c, input logic en);
        bus.i_spr_x1[12*k +: 12] = x1;
        bus.i_spr_x2[12*k +: 12] = x2;
        bus.i_spr_y1[12*k +: 12] = y1;
        bus.i_spr_y2[12*k +: 12] = y2;
        bus.i_spr_rgb[12*k +: 12] = c;
        bus.i_spr_en[k] = en;
    endtask

    initial begin
        rst            = 1'b0;
        bus.i_pix_stb  = 1'b0;
        bus.i_x        = '0;
        bus.i_y        = '0;
        bus.i_frame    = 1'b0;
        bus.i_spr_x1   = '0;
        bus.i_spr_x2   = '0;
        bus.i_spr_y1   = '0;
        bus.i_spr_y2   = '0;
        bus.i_spr_en   = '0;
        bus.i_spr_rgb  = '0;
        bus.i_bg_rgb   = 12'h000;
        bus.i_gameover = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_rgb",     rgb(),         32'h000);
        check("rst_overlap", 32'(bus.o_overlap), 32'h0);
        check("rst_state",   32'(bus.o_state),   32'h0);
        step();
        step();
        rst = 1'b0;

        // Single sprite and strict edges
        set_spr(0, 12'd100, 12'd110, 12'd200, 12'd210, 12'hF00, 1'b1);
        set_spr(1, 12'd300, 12'd301, 12'd0,   12'd400, 12'hFFF, 1'b1);
        show(10'd101, 9'd201);  check("single_inside",  rgb(), 32'hF00);
        show(10'd100, 9'd201);  check("single_edge_x1", rgb(), 32'h000);
        show(10'd109, 9'd209);  check("single_corner",  rgb(), 32'hF00);
        show(10'd110, 9'd205);  check("single_edge_x2", rgb(), 32'h000);
        show(10'd105, 9'd210);  check("single_edge_y2", rgb(), 32'h000);
        show(10'd301, 9'd201);  check("degenerate",     rgb(), 32'h000);
        set_spr(1, 12'd0, 12'd0, 12'd0, 12'd0, 12'h000, 1'b0);

        // Priority and overlap
        frame();
        check("ovl_none_initial", 32'(bus.o_overlap), 32'h00);
        set_spr(0, 12'd40, 12'd60, 12'd40, 12'd60, 12'h0F0, 1'b1);
        set_spr(3, 12'd45, 12'd55, 12'd45, 12'd55, 12'h00F, 1'b1);
        show(10'd50, 9'd50);    check("prio_low_wins", rgb(), 32'h0F0);
        strobe(10'd0, 9'd0);
        check("ovl_held", 32'(bus.o_overlap), 32'h00);
        frame();
        check("ovl_published", 32'(bus.o_overlap), 32'h09);
        bus.i_spr_en[0] = 1'b0;
        show(10'd50, 9'd50);    check("prio_disabled0", rgb(), 32'h00F);
        strobe(10'd0, 9'd0);
        frame();
        check("ovl_cleared", 32'(bus.o_overlap), 32'h00);

        // Collision registered on the same edge as the frame pulse
        bus.i_spr_en[0] = 1'b1;
        strobe(10'd50, 9'd50);
        bus.i_x       = 10'd0;
        bus.i_y       = 9'd0;
        bus.i_pix_stb = 1'b1;
        bus.i_frame   = 1'b1;
        step();
        bus.i_pix_stb = 1'b0;
        bus.i_frame   = 1'b0;
        check("ovl_same_edge", 32'(bus.o_overlap), 32'h09);
        frame();
        check("ovl_after_same", 32'(bus.o_overlap), 32'h00);

        // Game-over sequence
        set_spr(0, 12'd100, 12'd110, 12'd200, 12'd210, 12'hF00, 1'b1);
        set_spr(3, 12'd0, 12'd0, 12'd0, 12'd0, 12'h000, 1'b0);
        bus.i_bg_rgb   = 12'h123;
        bus.i_gameover = 1'b1;
        frame();
        check("flash_state", 32'(bus.o_state), 32'h1);
        show(10'd101, 9'd201);  check("flash_hidden", rgb(), 32'h123);
        frame();
        frame();
        check("flash_state2", 32'(bus.o_state), 32'h1);
        show(10'd101, 9'd201);  check("flash_visible", rgb(), 32'hF00);
        frame();
        check("flash_state3", 32'(bus.o_state), 32'h1);
        frame();
        check("over_state", 32'(bus.o_state), 32'h2);
        show(10'd101, 9'd201);  check("over_bg", rgb(), 32'h123);
        bus.i_gameover = 1'b0;
        frame();
        check("play_state", 32'(bus.o_state), 32'h0);
        show(10'd101, 9'd201);  check("play_visible", rgb(), 32'hF00);

        // Asynchronous reset from FLASH with nonzero outputs
        set_spr(3, 12'd100, 12'd110, 12'd200, 12'd210, 12'h00F, 1'b1);
        show(10'd101, 9'd201);
        bus.i_gameover = 1'b1;
        frame();
        check("pre_rst_overlap", 32'(bus.o_overlap), 32'h09);
        check("pre_rst_state",   32'(bus.o_state),   32'h1);
        show(10'd101, 9'd201);  check("pre_rst_rgb", rgb(), 32'h123);
        #2 rst = 1'b1;
        #1;
        check("arst_rgb",     rgb(),              32'h000);
        check("arst_state",   32'(bus.o_state),   32'h0);
        check("arst_overlap", 32'(bus.o_overlap), 32'h00);
        step();
        rst = 1'b0;
        bus.i_gameover = 1'b0;
        bus.i_spr_en[3] = 1'b0;
        strobe(10'd101, 9'd201); check("post_rst_1", rgb(), 32'h000);
        strobe(10'd101, 9'd201); check("post_rst_2", rgb(), 32'hF00);

        // Strobe gating
        for (int i = 0; i < 3; i++) begin
            bus.i_x = 10'(5 * i);
            bus.i_y = 9'(5 * i);
            step();
            check("gated_hold", rgb(), 32'hF00);
        end
        strobe(10'd0, 9'd0);    check("resume_1", rgb(), 32'hF00);
        strobe(10'd0, 9'd0);    check("resume_2", rgb(), 32'h123);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
